mem_lsu_ctrl: RTL and testbench

MEM-stage load/store controller between the EX/MEM pipeline register and the WB stage register. It converts the memory operation of the instruction in MEM into a single-outstanding SRAM-like request/response transaction. It holds the pipeline while the transaction is in flight and delivers the raw 32-bit load word as MEM_DMOut; sign/zero extension is done downstream in WB. It also buffers a response that arrives while WB is stalled.

---
 rtl/mem_lsu_ctrl_pkg.sv | 18 +
 rtl/mem_lsu_ctrl_align.sv | 17 +
 rtl/mem_lsu_ctrl.sv | 106 ++++++++++
 tb/tb_mem_lsu_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_ctrl_pkg.sv
// mem_lsu_ctrl_pkg: shared CPU defines for the MEM-stage load/store path (load/store kinds, size codes, LSU states)
package mem_lsu_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef struct packed {
    logic       ReadMem;
    logic [1:0] size;
  } LoadType;
  typedef struct packed {
    logic       WriteMem;
    logic [1:0] size;
  } StoreType;
  typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, HOLD, CANCEL} lsu_state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'd0);
  endfunction
endpackage

// File: rtl/mem_lsu_ctrl_align.sv
// lsu_store_align: byte-lane strobe and lane-replicated write data for a store
// Ports: wr (store), size (SZ_*), a (addr[1:0]), data (store value) -> wstrb, wdata (both 0 for loads)
module lsu_store_align
  import mem_lsu_ctrl_pkg::*;
(
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);
  always_comb begin
    wstrb = !wr ? 4'h0 : size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? 4'b0011 << a : 4'hF;
    wdata = !wr ? 32'h0 : size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
  end
endmodule

// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl: MEM-stage load/store controller driving a single-outstanding SRAM-like request/response port
// Pipeline side: MEM_Valid/LoadType/StoreType/ALUOut/OutB/Flush and WB_Wr in; MEM_DMOut, MEM_LSU_Stall,
//   MEM_AdEL/MEM_AdES/MEM_BadVAddr out. Memory side: data_req/wr/size/addr/wstrb/wdata out,
//   data_addr_ok/data_data_ok/data_rdata in. Define MEM_ADDR_CHECK_EN to trap misaligned half/word accesses.
module mem_lsu_ctrl
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_Flush,
  input  logic              WB_Wr,
  input  logic              MEM_Valid,
  input  LoadType           MEM_LoadType,
  input  StoreType          MEM_StoreType,
  input  logic [ADDR_W-1:0] MEM_ALUOut,
  input  logic [DATA_W-1:0] MEM_OutB,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] MEM_DMOut,
  output logic              MEM_LSU_Stall,
  output logic              MEM_AdEL,
  output logic              MEM_AdES,
  output logic [ADDR_W-1:0] MEM_BadVAddr
);
  lsu_state_t        state;
  logic              ld, st, mis, op, pend, cur_wr, q_wr;
  logic [1:0]        cur_size, q_size;
  logic [3:0]        al_wstrb, q_wstrb;
  logic [DATA_W-1:0] al_wdata, q_wdata, hold_q;
  logic [ADDR_W-1:0] q_addr;
  lsu_store_align u_align (
    .wr    (cur_wr),
    .size  (cur_size),
    .a     (MEM_ALUOut[1:0]),
    .data  (MEM_OutB),
    .wstrb (al_wstrb),
    .wdata (al_wdata)
  );
  always_comb begin
    cur_wr   = MEM_StoreType.WriteMem;
    cur_size = cur_wr ? MEM_StoreType.size : MEM_LoadType.size;
    ld       = MEM_Valid & MEM_LoadType.ReadMem;
    st       = MEM_Valid & MEM_StoreType.WriteMem;
`ifdef MEM_ADDR_CHECK_EN
    mis      = misaligned(cur_size, MEM_ALUOut[1:0]);
`else
    mis      = 1'b0;
`endif
    MEM_AdEL     = ld & mis;
    MEM_AdES     = st & mis;
    MEM_BadVAddr = (MEM_AdEL | MEM_AdES) ? MEM_ALUOut : '0;
    op       = (ld | st) & ~mis & ~MEM_Flush;
    pend     = state == WAIT_ADDR;
    data_req = pend | (state == IDLE & op);
    // once a request is waiting for acceptance it is driven from the captured copy
    data_wr    = data_req & (pend ? q_wr : cur_wr);
    data_size  = !data_req ? 2'd0 : pend ? q_size : cur_size;
    data_addr  = !data_req ? '0 : pend ? q_addr : MEM_ALUOut;
    data_wstrb = !data_req ? 4'h0 : pend ? q_wstrb : al_wstrb;
    data_wdata = !data_req ? '0 : pend ? q_wdata : al_wdata;
    MEM_DMOut  = state == HOLD ? hold_q : (state == WAIT_DATA & data_data_ok & ~MEM_Flush) ? data_rdata : '0;
    MEM_LSU_Stall = (state == IDLE & op) | pend | (state == WAIT_DATA & ~data_data_ok) | state == CANCEL;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      hold_q  <= '0;
      q_wr    <= 1'b0;
      q_size  <= 2'd0;
      q_addr  <= '0;
      q_wstrb <= 4'h0;
      q_wdata <= '0;
    end else
      case (state)
        IDLE:
          if (op) begin
            state   <= data_addr_ok ? WAIT_DATA : WAIT_ADDR;
            q_wr    <= cur_wr;
            q_size  <= cur_size;
            q_addr  <= MEM_ALUOut;
            q_wstrb <= al_wstrb;
            q_wdata <= al_wdata;
          end
        // a flush that coincides with acceptance still owes a response, so drain it in CANCEL
        WAIT_ADDR: state <= data_addr_ok ? (MEM_Flush ? CANCEL : WAIT_DATA) : (MEM_Flush ? IDLE : WAIT_ADDR);
        WAIT_DATA:
          if (MEM_Flush) state <= data_data_ok ? IDLE : CANCEL;
          else if (data_data_ok) begin
            state  <= WB_Wr ? IDLE : HOLD;
            hold_q <= data_rdata;
          end
        HOLD:    if (WB_Wr | MEM_Flush) state <= IDLE;
        CANCEL:  if (data_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb_mem_lsu_ctrl: directed literal checks plus randomized traffic against a transaction-level model
module tb_mem_lsu_ctrl;
  import mem_lsu_ctrl_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        MEM_Flush, WB_Wr, MEM_Valid;
  LoadType     MEM_LoadType;
  StoreType    MEM_StoreType;
  logic [31:0] MEM_ALUOut, MEM_OutB;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, MEM_DMOut, MEM_BadVAddr;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok, MEM_LSU_Stall, MEM_AdEL, MEM_AdES;
  int total = 0, bad = 0;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  mem_lsu_ctrl dut (
    .clk(clk), .rst(rst), .MEM_Flush(MEM_Flush), .WB_Wr(WB_Wr), .MEM_Valid(MEM_Valid),
    .MEM_LoadType(MEM_LoadType), .MEM_StoreType(MEM_StoreType), .MEM_ALUOut(MEM_ALUOut),
    .MEM_OutB(MEM_OutB), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .MEM_DMOut(MEM_DMOut), .MEM_LSU_Stall(MEM_LSU_Stall), .MEM_AdEL(MEM_AdEL),
    .MEM_AdES(MEM_AdES), .MEM_BadVAddr(MEM_BadVAddr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: pending request, outstanding transaction (maybe cancelled), held response
  logic        m_pend = 0, m_out = 0, m_canc = 0, m_hv = 0, q_wr = 0;
  logic [31:0] m_hval = 0, q_addr = 0, q_wd = 0, c_wd, e_dm;
  logic [3:0]  q_strb = 0, c_strb;
  logic [1:0]  q_sz = 0, e_sz;
  logic        e_ld, e_st, e_mis, e_op, issue, e_req, c_wr, o_pend, o_out, o_canc, o_hv;
  logic        acc_seen = 0, dok_seen = 0;
  int          a;
  always @(negedge clk)
    if (rst) begin
      m_pend = 0; m_out = 0; m_canc = 0; m_hv = 0; m_hval = 0; acc_seen = 0; dok_seen = 0;
    end else begin
      c_wr  = MEM_StoreType.WriteMem;
      e_sz  = c_wr ? MEM_StoreType.size : MEM_LoadType.size;
      e_ld  = MEM_Valid && MEM_LoadType.ReadMem;
      e_st  = MEM_Valid && MEM_StoreType.WriteMem;
      a     = int'(MEM_ALUOut % 4);
      e_mis = CHK && ((e_sz == SZ_HALF && a % 2 == 1) || (e_sz == SZ_WORD && a != 0));
      e_op  = (e_ld || e_st) && !e_mis && !MEM_Flush;
      issue = !(m_pend || m_out || m_hv) && e_op;
      e_req = m_pend || issue;
      c_strb = !c_wr ? 4'h0 : e_sz == SZ_BYTE ? 4'(1 << a) : e_sz == SZ_HALF ? 4'(3 << a) : 4'hF;
      c_wd   = !c_wr ? 32'h0 : e_sz == SZ_BYTE ? 32'(MEM_OutB[7:0]) * 32'h01010101 :
               e_sz == SZ_HALF ? 32'(MEM_OutB[15:0]) * 32'h00010001 : MEM_OutB;
      chk("req", 32'(data_req), 32'(e_req));
      if (e_req) begin
        chk("wr", 32'(data_wr), 32'(m_pend ? q_wr : c_wr));
        chk("size", 32'(data_size), 32'(m_pend ? q_sz : e_sz));
        chk("addr", data_addr, m_pend ? q_addr : MEM_ALUOut);
        chk("wstrb", 32'(data_wstrb), 32'(m_pend ? q_strb : c_strb));
        chk("wdata", data_wdata, m_pend ? q_wd : c_wd);
      end
      e_dm = m_hv ? m_hval : (m_out && !m_canc && data_data_ok && !MEM_Flush) ? data_rdata : 32'h0;
      chk("dmout", MEM_DMOut, e_dm);
      chk("stall", 32'(MEM_LSU_Stall), 32'(issue || m_pend || (m_out && (m_canc || !data_data_ok))));
      chk("adel", 32'(MEM_AdEL), 32'(e_ld && e_mis));
      chk("ades", 32'(MEM_AdES), 32'(e_st && e_mis));
      chk("badva", MEM_BadVAddr, ((e_ld || e_st) && e_mis) ? MEM_ALUOut : 32'h0);
      acc_seen = e_req && data_addr_ok;
      dok_seen = data_data_ok;
      o_pend = m_pend; o_out = m_out; o_canc = m_canc; o_hv = m_hv;
      if (o_hv && (WB_Wr || MEM_Flush)) m_hv = 0;
      if (o_out && data_data_ok) begin
        m_out = 0;
        if (!o_canc && !MEM_Flush && !WB_Wr) begin m_hv = 1; m_hval = data_rdata; end
      end else if (o_out && MEM_Flush) m_canc = 1;
      if (o_pend) begin
        if (data_addr_ok) begin m_pend = 0; m_out = 1; m_canc = MEM_Flush; end
        else if (MEM_Flush) m_pend = 0;
      end else if (issue) begin
        if (data_addr_ok) begin m_out = 1; m_canc = 0; end
        else begin m_pend = 1; q_wr = c_wr; q_sz = e_sz; q_addr = MEM_ALUOut; q_strb = c_strb; q_wd = c_wd; end
      end
    end
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    MEM_Valid = 0; MEM_Flush = 0; WB_Wr = 1; MEM_LoadType = '0; MEM_StoreType = '0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask
  task automatic ld_in(input logic [31:0] ad, input logic [1:0] sz);
    MEM_Valid = 1; MEM_LoadType = '{ReadMem: 1'b1, size: sz}; MEM_StoreType = '0; MEM_ALUOut = ad;
  endtask
  task automatic st_in(input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] d);
    MEM_Valid = 1; MEM_LoadType = '0; MEM_StoreType = '{WriteMem: 1'b1, size: sz}; MEM_ALUOut = ad; MEM_OutB = d;
  endtask
  logic mem_out;
  logic [1:0] rsz;
  int k;
  initial begin
    idle_in(); MEM_ALUOut = 0; MEM_OutB = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(data_req), 0); chk("rst_stall", 32'(MEM_LSU_Stall), 0);
    chk("rst_dm", MEM_DMOut, 0); chk("rst_adel", 32'(MEM_AdEL), 0); chk("rst_badva", MEM_BadVAddr, 0);
    go(); rst = 0;
    // best-case word load
    go(); ld_in(32'h8000_0010, SZ_WORD); data_addr_ok = 1;
    @(negedge clk); chk("t1_req", 32'(data_req), 1); chk("t1_addr", data_addr, 32'h8000_0010);
    chk("t1_size", 32'(data_size), 2); chk("t1_stall", 32'(MEM_LSU_Stall), 1);
    go(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("t1_dm", MEM_DMOut, 32'hDEAD_BEEF); chk("t1_stall2", 32'(MEM_LSU_Stall), 0);
    go(); idle_in();
    @(negedge clk); chk("t1_dm0", MEM_DMOut, 0);
    // byte store at ...03
    go(); st_in(32'h0000_1003, SZ_BYTE, 32'h1234_56AB); data_addr_ok = 1;
    @(negedge clk); chk("t2_wstrb", 32'(data_wstrb), 32'h8); chk("t2_wdata", data_wdata, 32'hABAB_ABAB);
    chk("t2_size", 32'(data_size), 0); chk("t2_wr", 32'(data_wr), 1);
    go(); data_addr_ok = 0; data_data_ok = 1;
    go(); idle_in();
    // addr_ok delayed three cycles; live inputs drift but the request must not
    go(); st_in(32'h0000_0100, SZ_WORD, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin go(); MEM_ALUOut = 32'h100 + 32'(i * 4); MEM_OutB = 32'(i); end
      data_addr_ok = i == 3;
      @(negedge clk); chk("t3_req", 32'(data_req), 1); chk("t3_addr", data_addr, 32'h100);
      chk("t3_wdata", data_wdata, 32'hCAFE_F00D); chk("t3_stall", 32'(MEM_LSU_Stall), 1);
    end
    go(); idle_in();
    @(negedge clk); chk("t3_stall5", 32'(MEM_LSU_Stall), 1); chk("t3_req5", 32'(data_req), 0);
    go(); data_data_ok = 1;
    @(negedge clk); chk("t3_stall6", 32'(MEM_LSU_Stall), 0);
    go(); idle_in();
    // response while WB stalled
    go(); ld_in(32'h200, SZ_WORD); data_addr_ok = 1; WB_Wr = 0;
    go(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1234_5678;
    @(negedge clk); chk("t4_dm", MEM_DMOut, 32'h1234_5678); chk("t4_stall", 32'(MEM_LSU_Stall), 0);
    repeat (2) begin
      go(); data_data_ok = 0; data_rdata = 0;
      @(negedge clk); chk("t4_hold", MEM_DMOut, 32'h1234_5678); chk("t4_hstall", 32'(MEM_LSU_Stall), 0);
      chk("t4_hreq", 32'(data_req), 0);
    end
    go(); WB_Wr = 1;
    @(negedge clk); chk("t4_wb", MEM_DMOut, 32'h1234_5678);
    go(); idle_in();
    @(negedge clk); chk("t4_dm0", MEM_DMOut, 0);
    // flush while waiting for data
    go(); ld_in(32'h300, SZ_WORD); data_addr_ok = 1;
    go(); data_addr_ok = 0; MEM_Flush = 1;
    go(); MEM_Flush = 0; ld_in(32'h400, SZ_WORD);
    @(negedge clk); chk("t5_req", 32'(data_req), 0); chk("t5_stall", 32'(MEM_LSU_Stall), 1);
    go(); data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
    @(negedge clk); chk("t5_req2", 32'(data_req), 0); chk("t5_dm", MEM_DMOut, 0);
    go(); data_data_ok = 0; data_addr_ok = 1;
    @(negedge clk); chk("t5_req3", 32'(data_req), 1); chk("t5_addr", data_addr, 32'h400);
    go(); data_addr_ok = 0; data_data_ok = 1;
    go(); idle_in();
    // misaligned word load
    go(); ld_in(32'h8000_0002, SZ_WORD); data_addr_ok = 1;
    @(negedge clk);
    chk("t6_adel", 32'(MEM_AdEL), 32'(CHK)); chk("t6_badva", MEM_BadVAddr, CHK ? 32'h8000_0002 : 32'h0);
    chk("t6_req", 32'(data_req), 32'(!CHK)); chk("t6_stall", 32'(MEM_LSU_Stall), 32'(!CHK));
    go(); idle_in();
`ifndef MEM_ADDR_CHECK_EN
    data_data_ok = 1;
    go(); idle_in();
`endif
    // randomized traffic with a protocol-correct memory responder
    mem_out = 0;
    for (int c = 0; c < 4000; c++) begin
      go();
      if (dok_seen) mem_out = 0;
      if (acc_seen) mem_out = 1;
      if (c == 2000) begin
        rst = 1; idle_in(); mem_out = 0;
        go(); rst = 0;
        continue;
      end
      if ($urandom_range(3) == 0) begin
        k = int'($urandom_range(2)); rsz = 2'($urandom_range(2));
        MEM_Valid = $urandom_range(3) != 0;
        MEM_LoadType = '{ReadMem: k == 0, size: rsz};
        MEM_StoreType = '{WriteMem: k == 1, size: rsz};
        MEM_ALUOut = $urandom();
        if ($urandom_range(1) == 1) MEM_ALUOut[1:0] = rsz == SZ_WORD ? 2'd0 : rsz == SZ_HALF ? {MEM_ALUOut[1], 1'b0} : MEM_ALUOut[1:0];
      end
      MEM_OutB = $urandom();
      MEM_Flush = $urandom_range(9) == 0;
      WB_Wr = $urandom_range(1) == 1;
      data_addr_ok = $urandom_range(1) == 1;
      data_data_ok = mem_out && ($urandom_range(1) == 1);
      data_rdata = $urandom();
    end
    go(); idle_in();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
